cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  Shares the single 256-bit line-refill memory port between the icache refill path and
//  the dcache (refill read + dirty-line writeback). Sits between the caches and the
//  memory/bus bridge. One transaction outstanding at a time; responses are routed back
//  to the owner. Read arbitration is round-robin; a pending writeback wins over reads.
// PARAMETERS
//  OFFSET_SIZE  5    line offset bits; issued addresses are line-aligned (low bits zeroed)
//  ADDR_W       32   address width
//  LINE_W       256  line width (bus256_t)
// PORTS
//  clk               in   1    clock
//  reset             in   1    synchronous, active-high reset
//  icache_rd_req     in   1    level; held high until icache_ret_valid seen
//  icache_rd_addr    in   32   refill address, held stable with req
//  icache_ret_valid  out  1    one-cycle pulse, refill data valid
//  icache_ret_data   out  256  refill line
//  dcache_rd_req     in   1    level; held until dcache_ret_valid
//  dcache_rd_addr    in   32   refill address
//  dcache_ret_valid  out  1    one-cycle pulse
//  dcache_ret_data   out  256  refill line
//  dcache_wr_req     in   1    level; held until dcache_wr_done
//  dcache_wr_addr    in   32   writeback address
//  dcache_wr_data    in   256  writeback line
//  dcache_wr_done    out  1    one-cycle pulse, write accepted by memory
//  mem_rd_req        out  1    one-cycle pulse per read
//  mem_rd_addr       out  32   line-aligned read address
//  mem_ret_valid     in   1    read data valid (>=1 cycle after mem_rd_req)
//  mem_ret_data      in   256  read line
//  mem_wr_req        out  1    one-cycle pulse per write
//  mem_wr_addr       out  32   line-aligned write address
//  mem_wr_data       out  256  write line
//  mem_wr_done       in   1    write completion (>=1 cycle after mem_wr_req)
// BEHAVIOUR
//  - States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT. Registers: owner (I/D), rr_last, addr/data latches.
//  - IDLE: if dcache_wr_req -> WR_REQ (latch addr/data). Else if both reads -> grant side != rr_last;
//    else grant the single requester -> RD_REQ (latch line-aligned addr, owner). Else stay.
//  - RD_REQ: mem_rd_req=1 for exactly this cycle -> RD_WAIT. WR_REQ: mem_wr_req=1 -> WR_WAIT.
//  - RD_WAIT: on mem_ret_valid, owner's *_ret_valid=1 and *_ret_data=mem_ret_data combinationally
//    in the same cycle; rr_last<=owner; -> IDLE. Non-owner ret_valid stays 0.
//  - WR_WAIT: on mem_wr_done, dcache_wr_done=1 same cycle -> IDLE.
//  - Latency: req visible in IDLE cycle 0 -> mem_*_req cycle 1 -> earliest response/done cycle 2.
//  - Requesters drop req the cycle after their ret/done pulse; IDLE re-samples then (no bubble
//    beyond the one IDLE cycle). Requests cannot be withdrawn once granted.
//  - mem_rd_addr/mem_wr_addr = {addr[31:OFFSET_SIZE], OFFSET_SIZE'b0}, held from latch.
//  - mem_ret_valid / mem_wr_done outside RD_WAIT / WR_WAIT: ignored, no output pulses.
//  - Reset (any state, incl. mid-transaction): state=IDLE, rr_last=D (icache preferred first),
//    all *_req/*_valid/*_done outputs 0, data/addr outputs 0; late memory responses ignored.
//  - ret_data outputs driven 0 whenever the matching ret_valid is 0.
// STRUCTURE
//  - Shared package: bus32_t, bus256_t typedefs, OFFSET_SIZE constant, arb_state_t enum.
//  - Sub-module rr_arb2: 2-input round-robin grant from (req_i, req_d, rr_last); combinational.
//  - FSM, latches and response routing in cache_mem_arbiter itself.
// TESTING
//  - icache read 0x0000_0024 -> mem_rd_req 1 cycle, mem_rd_addr 0x0000_0020; mem returns
//    line 0x..1C.._00 -> icache_ret_valid 1 cycle with that data, dcache_ret_valid stays 0.
//  - After reset, icache+dcache read together -> icache served first, dcache second; repeat
//    both -> icache first again (rr_last=D after dcache served); exactly 2 mem_rd_req per round.
//  - dcache_wr_req (0x0000_1040, data 0xA5..A5) + icache read same cycle -> mem_wr_req first
//    with addr 0x0000_1040 and data 0xA5..A5; dcache_wr_done on mem_wr_done; then icache read.
//  - Spurious mem_ret_valid / mem_wr_done in IDLE -> no ret_valid/wr_done pulses, state IDLE.
//  - reset asserted in RD_WAIT -> next cycle all outputs 0, IDLE; mem_ret_valid 2 cycles later ignored.
//  - Memory latency 1 and 7 cycles -> data routed to correct owner, no duplicate mem_rd_req.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache/memory line-refill arbiter.
// Holds the bus typedefs, FSM state and owner encodings, and the line-align helper.
package cache_mem_arbiter_pkg;

    localparam int unsigned OFFSET_SIZE = 5;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned LINE_W      = 256;

    typedef logic [ADDR_W-1:0] bus32_t;
    typedef logic [LINE_W-1:0] bus256_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_WAIT = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam bus32_t LINE_MASK = ~bus32_t'((1 << OFFSET_SIZE) - 1);

    // Clear the line-offset bits so the memory port only ever sees line addresses.
    function automatic bus32_t line_align(input bus32_t addr);
        return addr & LINE_MASK;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of the cache-side request/response signals and the memory-port signals.
// master: the arbiter; slave: the caches and memory bridge around it.
interface cache_mem_arbiter_if;
    import cache_mem_arbiter_pkg::*;

    logic    icache_rd_req;
    bus32_t  icache_rd_addr;
    logic    icache_ret_valid;
    bus256_t icache_ret_data;

    logic    dcache_rd_req;
    bus32_t  dcache_rd_addr;
    logic    dcache_ret_valid;
    bus256_t dcache_ret_data;

    logic    dcache_wr_req;
    bus32_t  dcache_wr_addr;
    bus256_t dcache_wr_data;
    logic    dcache_wr_done;

    logic    mem_rd_req;
    bus32_t  mem_rd_addr;
    logic    mem_ret_valid;
    bus256_t mem_ret_data;

    logic    mem_wr_req;
    bus32_t  mem_wr_addr;
    bus256_t mem_wr_data;
    logic    mem_wr_done;

    modport master (
        input  icache_rd_req, icache_rd_addr,
        output icache_ret_valid, icache_ret_data,
        input  dcache_rd_req, dcache_rd_addr,
        output dcache_ret_valid, dcache_ret_data,
        input  dcache_wr_req, dcache_wr_addr, dcache_wr_data,
        output dcache_wr_done,
        output mem_rd_req, mem_rd_addr,
        input  mem_ret_valid, mem_ret_data,
        output mem_wr_req, mem_wr_addr, mem_wr_data,
        input  mem_wr_done
    );

    modport slave (
        output icache_rd_req, icache_rd_addr,
        input  icache_ret_valid, icache_ret_data,
        output dcache_rd_req, dcache_rd_addr,
        input  dcache_ret_valid, dcache_ret_data,
        output dcache_wr_req, dcache_wr_addr, dcache_wr_data,
        input  dcache_wr_done,
        input  mem_rd_req, mem_rd_addr,
        output mem_ret_valid, mem_ret_data,
        input  mem_wr_req, mem_wr_addr, mem_wr_data,
        output mem_wr_done
    );

endinterface

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Two-way round-robin read grant between icache and dcache.
// When both request, the side that was not served last wins.
module cache_mem_arbiter_rr_arb2
    import cache_mem_arbiter_pkg::*;
(
    input  logic   icache_req_i,
    input  logic   dcache_req_i,
    input  owner_t rr_last_i,
    output logic   gnt_valid_o,
    output owner_t gnt_owner_o
);

    always_comb begin
        gnt_valid_o = icache_req_i | dcache_req_i;
        gnt_owner_o = OWN_I;
        if (icache_req_i && dcache_req_i) begin
            gnt_owner_o = (rr_last_i == OWN_I) ? OWN_D : OWN_I;
        end else if (dcache_req_i) begin
            gnt_owner_o = OWN_D;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares the single 256-bit line memory port between icache refill and dcache refill/writeback.
// One transaction in flight; writeback beats reads; reads alternate round-robin.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
(
    input logic                 clk,
    input logic                 reset,
    cache_mem_arbiter_if.master bus
);

    arb_state_t state_q;
    owner_t     owner_q;
    owner_t     rr_last_q;
    bus32_t     addr_q;
    bus256_t    wdata_q;
    logic       mem_rd_req_q;
    logic       mem_wr_req_q;

    logic       gnt_valid;
    owner_t     gnt_owner;
    bus32_t     rd_addr_d;
    bus32_t     wr_addr_d;
    logic       rd_resp;
    logic       wr_resp;

    cache_mem_arbiter_rr_arb2 u_rr_arb2 (
        .icache_req_i (bus.icache_rd_req),
        .dcache_req_i (bus.dcache_rd_req),
        .rr_last_i    (rr_last_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_owner_o  (gnt_owner)
    );

    assign rd_addr_d = line_align((gnt_owner == OWN_I) ? bus.icache_rd_addr : bus.dcache_rd_addr);
    assign wr_addr_d = line_align(bus.dcache_wr_addr);

    // Memory responses only count while waiting for them; reset squashes any in-flight one.
    assign rd_resp = !reset && (state_q == ST_RD_WAIT) && bus.mem_ret_valid;
    assign wr_resp = !reset && (state_q == ST_WR_WAIT) && bus.mem_wr_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_D;
            rr_last_q    <= OWN_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
        end else begin
            mem_rd_req_q <= 1'b0;
            mem_wr_req_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.dcache_wr_req) begin
                        state_q      <= ST_WR_REQ;
                        addr_q       <= wr_addr_d;
                        wdata_q      <= bus.dcache_wr_data;
                        mem_wr_req_q <= 1'b1;
                    end else if (gnt_valid) begin
                        state_q      <= ST_RD_REQ;
                        owner_q      <= gnt_owner;
                        addr_q       <= rd_addr_d;
                        mem_rd_req_q <= 1'b1;
                    end
                end
                ST_RD_REQ: state_q <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (rd_resp) begin
                        rr_last_q <= owner_q;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_WR_REQ: state_q <= ST_WR_WAIT;
                ST_WR_WAIT: begin
                    if (wr_resp) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Response routing: only the owner sees the pulse, and data is zero unless valid.
    assign bus.icache_ret_valid = rd_resp && (owner_q == OWN_I);
    assign bus.dcache_ret_valid = rd_resp && (owner_q == OWN_D);
    assign bus.icache_ret_data  = bus.icache_ret_valid ? bus.mem_ret_data : '0;
    assign bus.dcache_ret_data  = bus.dcache_ret_valid ? bus.mem_ret_data : '0;
    assign bus.dcache_wr_done   = wr_resp;

    assign bus.mem_rd_req  = mem_rd_req_q;
    assign bus.mem_rd_addr = addr_q;
    assign bus.mem_wr_req  = mem_wr_req_q;
    assign bus.mem_wr_addr = addr_q;
    assign bus.mem_wr_data = wdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: port-level transaction model plus directed scenarios.
// The bench plays both caches and a fixed-latency memory that returns an address-derived line.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    localparam int unsigned K_NONE = 0;
    localparam int unsigned K_RDI  = 1;
    localparam int unsigned K_RDD  = 2;
    localparam int unsigned K_WR   = 3;
    localparam logic [31:0] ALIGN  = 32'hFFFF_FFE0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;

    // transaction model state
    int unsigned m_exp = K_NONE;
    int unsigned m_out = K_NONE;
    logic        m_free = 1'b1;
    logic        m_rr_d = 1'b1;
    logic        after_rst = 1'b0;
    logic [31:0] m_exp_addr = '0;
    logic [31:0] m_out_addr = '0;
    logic [255:0] m_exp_data = '0;

    // observations used by the directed checks and the memory/cache behaviour
    int n_rd = 0, n_wr = 0, n_iret = 0, n_dret = 0, n_wd = 0;
    int rd_cyc = 0, iret_cyc = 0;
    logic [31:0]  last_rd_addr = '0, last_wr_addr = '0;
    logic [255:0] last_wr_data = '0, last_iret_data = '0;
    string log = "";
    logic s_iret = 0, s_dret = 0, s_wd = 0, s_rd = 0, s_wr = 0, s_rst = 0;
    logic [31:0] s_rd_addr = '0;
    logic rd_pend = 0, wr_pend = 0, inj_ret = 0, inj_wd = 0;
    int rd_due = 0, wr_due = 0;
    logic [255:0] rd_line = '0;

    function automatic logic [255:0] line_for(input logic [31:0] a);
        return {8{a ^ 32'h1C1C_1C00}};
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk256(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_s(input string nm, input string act, input string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got '%s' expected '%s'", nm, act, exp);
        end
    endtask

    // Per-cycle comparison of every DUT output against the transaction model.
    task automatic compare();
        logic ei, ed, ew;
        int unsigned nexp;
        if (reset) begin
            m_free = 1'b1; m_rr_d = 1'b1; m_out = K_NONE; m_exp = K_NONE;
            after_rst = 1'b1; s_rst = 1'b1;
            s_iret = 0; s_dret = 0; s_wd = 0; s_rd = 0; s_wr = 0;
            return;
        end
        s_rst = 1'b0;
        if (after_rst) begin
            chk32("reset_ctrl", {27'd0, bus.icache_ret_valid, bus.dcache_ret_valid,
                  bus.dcache_wr_done, bus.mem_rd_req, bus.mem_wr_req}, 32'd0);
            chk32("reset_rd_addr", bus.mem_rd_addr, 32'd0);
            chk32("reset_wr_addr", bus.mem_wr_addr, 32'd0);
            chk256("reset_wr_data", bus.mem_wr_data, '0);
        end
        after_rst = 1'b0;

        chk1("mem_rd_req", bus.mem_rd_req, (m_exp == K_RDI) || (m_exp == K_RDD));
        chk1("mem_wr_req", bus.mem_wr_req, m_exp == K_WR);
        if (m_exp == K_RDI || m_exp == K_RDD) chk32("mem_rd_addr", bus.mem_rd_addr, m_exp_addr);
        if (m_exp == K_WR) begin
            chk32("mem_wr_addr", bus.mem_wr_addr, m_exp_addr);
            chk256("mem_wr_data", bus.mem_wr_data, m_exp_data);
        end

        ei = (m_out == K_RDI) && bus.mem_ret_valid;
        ed = (m_out == K_RDD) && bus.mem_ret_valid;
        ew = (m_out == K_WR) && bus.mem_wr_done;
        chk1("icache_ret_valid", bus.icache_ret_valid, ei);
        chk1("dcache_ret_valid", bus.dcache_ret_valid, ed);
        chk1("dcache_wr_done", bus.dcache_wr_done, ew);
        chk256("icache_ret_data", bus.icache_ret_data, ei ? line_for(m_out_addr) : '0);
        chk256("dcache_ret_data", bus.dcache_ret_data, ed ? line_for(m_out_addr) : '0);

        if (bus.mem_rd_req) begin n_rd++; last_rd_addr = bus.mem_rd_addr; rd_cyc = cyc; end
        if (bus.mem_wr_req) begin n_wr++; last_wr_addr = bus.mem_wr_addr; last_wr_data = bus.mem_wr_data; end
        if (bus.icache_ret_valid) begin n_iret++; iret_cyc = cyc; last_iret_data = bus.icache_ret_data; log = {log, "I"}; end
        if (bus.dcache_ret_valid) begin n_dret++; log = {log, "D"}; end
        if (bus.dcache_wr_done) begin n_wd++; log = {log, "W"}; end
        s_iret = bus.icache_ret_valid; s_dret = bus.dcache_ret_valid; s_wd = bus.dcache_wr_done;
        s_rd = bus.mem_rd_req; s_rd_addr = bus.mem_rd_addr; s_wr = bus.mem_wr_req;

        if (ei || ed) m_rr_d = ed;
        if (ei || ed || ew) m_out = K_NONE;
        if (m_exp != K_NONE) begin m_out = m_exp; m_out_addr = m_exp_addr; end
        nexp = K_NONE;
        if (m_free) begin
            if (bus.dcache_wr_req) begin
                nexp = K_WR; m_exp_addr = bus.dcache_wr_addr & ALIGN; m_exp_data = bus.dcache_wr_data;
            end else if (bus.icache_rd_req && (!bus.dcache_rd_req || m_rr_d)) begin
                nexp = K_RDI; m_exp_addr = bus.icache_rd_addr & ALIGN;
            end else if (bus.dcache_rd_req) begin
                nexp = K_RDD; m_exp_addr = bus.dcache_rd_addr & ALIGN;
            end
        end
        m_free = (m_free && nexp == K_NONE) || ei || ed || ew;
        m_exp = nexp;
    endtask

    // Caches drop requests after their pulse; memory answers `lat` cycles after each request.
    task automatic env();
        bus.mem_ret_valid = 1'b0; bus.mem_ret_data = '0; bus.mem_wr_done = 1'b0;
        if (s_iret) bus.icache_rd_req = 1'b0;
        if (s_dret) bus.dcache_rd_req = 1'b0;
        if (s_wd) bus.dcache_wr_req = 1'b0;
        if (s_rst) begin rd_pend = 1'b0; wr_pend = 1'b0; end
        if (s_rd) begin rd_pend = 1'b1; rd_due = cyc - 1 + lat; rd_line = line_for(s_rd_addr); end
        if (s_wr) begin wr_pend = 1'b1; wr_due = cyc - 1 + lat; end
        if (rd_pend && cyc == rd_due) begin
            bus.mem_ret_valid = 1'b1; bus.mem_ret_data = rd_line; rd_pend = 1'b0;
        end
        if (wr_pend && cyc == wr_due) begin bus.mem_wr_done = 1'b1; wr_pend = 1'b0; end
        if (inj_ret) begin bus.mem_ret_valid = 1'b1; bus.mem_ret_data = {8{32'hDEAD_BEEF}}; inj_ret = 1'b0; end
        if (inj_wd) begin bus.mem_wr_done = 1'b1; inj_wd = 1'b0; end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        @(posedge clk);
        cyc++;
        #1;
        env();
    endtask

    task automatic wait_quiet(input string nm);
        int n = 0;
        while ((bus.icache_rd_req || bus.dcache_rd_req || bus.dcache_wr_req ||
                !m_free || rd_pend || wr_pend) && n < 200) begin
            step();
            n++;
        end
        chk1({nm, "_timeout"}, n < 200, 1'b1);
        step();
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.icache_rd_req = 0; bus.dcache_rd_req = 0; bus.dcache_wr_req = 0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        int s, b_rd, b_wr, b_i, b_d, b_w, n;
        bus.icache_rd_req = 0; bus.icache_rd_addr = '0;
        bus.dcache_rd_req = 0; bus.dcache_rd_addr = '0;
        bus.dcache_wr_req = 0; bus.dcache_wr_addr = '0; bus.dcache_wr_data = '0;
        bus.mem_ret_valid = 0; bus.mem_ret_data = '0; bus.mem_wr_done = 0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // single icache read, minimum memory latency
        lat = 1; log = ""; b_rd = n_rd; b_d = n_dret; s = cyc;
        bus.icache_rd_addr = 32'h0000_0024; bus.icache_rd_req = 1;
        wait_quiet("t1");
        chk32("t1_rd_cnt", n_rd - b_rd, 1);
        chk32("t1_rd_addr", last_rd_addr, 32'h0000_0020);
        chk32("t1_req_lat", rd_cyc - s, 1);
        chk32("t1_ret_lat", iret_cyc - s, 2);
        chk256("t1_iret_data", last_iret_data, {8{32'h1C1C_1C20}});
        chk32("t1_dret_cnt", n_dret - b_d, 0);

        // round-robin after reset: icache first, twice
        do_reset();
        lat = 3;
        for (int r = 0; r < 2; r++) begin
            log = ""; b_rd = n_rd;
            bus.icache_rd_addr = 32'h0000_0100 + 32'(r); bus.icache_rd_req = 1;
            bus.dcache_rd_addr = 32'h0000_2048; bus.dcache_rd_req = 1;
            wait_quiet("t2");
            chk_s("t2_order", log, "ID");
            chk32("t2_rd_cnt", n_rd - b_rd, 2);
        end

        // writeback beats a simultaneous icache read
        lat = 2; log = ""; b_wr = n_wr;
        bus.dcache_wr_addr = 32'h0000_1040; bus.dcache_wr_data = {32{8'hA5}}; bus.dcache_wr_req = 1;
        bus.icache_rd_addr = 32'h0000_0024; bus.icache_rd_req = 1;
        wait_quiet("t3");
        chk_s("t3_order", log, "WI");
        chk32("t3_wr_cnt", n_wr - b_wr, 1);
        chk32("t3_wr_addr", last_wr_addr, 32'h0000_1040);
        chk256("t3_wr_data", last_wr_data, {32{8'hA5}});
        chk32("t3_rd_addr", last_rd_addr, 32'h0000_0020);

        // spurious memory responses while idle
        b_i = n_iret; b_d = n_dret; b_w = n_wd;
        inj_ret = 1; step();
        inj_wd = 1; step();
        step(); step();
        chk32("t4_spur_i", n_iret - b_i, 0);
        chk32("t4_spur_d", n_dret - b_d, 0);
        chk32("t4_spur_w", n_wd - b_w, 0);
        lat = 1; s = cyc;
        bus.icache_rd_addr = 32'h0000_3004; bus.icache_rd_req = 1;
        wait_quiet("t4");
        chk32("t4_req_lat", rd_cyc - s, 1);
        chk32("t4_rd_addr", last_rd_addr, 32'h0000_3000);

        // reset while waiting for read data; late response must be ignored
        lat = 7; b_rd = n_rd; b_d = n_dret;
        bus.dcache_rd_addr = 32'h0000_0500; bus.dcache_rd_req = 1;
        n = 0;
        while (n_rd == b_rd && n < 20) begin step(); n++; end
        chk1("t5_req_seen", n < 20, 1'b1);
        reset = 1'b1; bus.dcache_rd_req = 0;
        step();
        reset = 1'b0;
        inj_ret = 1;
        step();
        repeat (3) step();
        chk32("t5_dret_cnt", n_dret - b_d, 0);

        // long latency, both reads, fresh round-robin state
        log = ""; b_rd = n_rd;
        bus.icache_rd_addr = 32'h0000_7040; bus.icache_rd_req = 1;
        bus.dcache_rd_addr = 32'h0000_7000; bus.dcache_rd_req = 1;
        wait_quiet("t6");
        chk_s("t6_order", log, "ID");
        chk32("t6_rd_cnt", n_rd - b_rd, 2);

        // latency 1: icache served alone, then dcache wins the next tie
        lat = 1; log = "";
        bus.icache_rd_addr = 32'h0000_0900; bus.icache_rd_req = 1;
        wait_quiet("t7a");
        b_rd = n_rd;
        bus.icache_rd_addr = 32'h0000_0A00; bus.icache_rd_req = 1;
        bus.dcache_rd_addr = 32'h0000_0B1F; bus.dcache_rd_req = 1;
        wait_quiet("t7b");
        chk_s("t7_order", log, "IDI");
        chk32("t7_rd_cnt", n_rd - b_rd, 2);
        chk32("t7_last_addr", last_rd_addr, 32'h0000_0A00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
